// File: rtl/mem_bus_mux_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_mux_pkg
// Shared memory-map constants and types for the CPU-to-core bus multiplexer:
//   - address prefixes (cpu_addr[31:24]) of the application FPGA cores
//   - prefix masks for area-wide and exact-core matching
//   - default illegal-instruction word returned on forced traps
//   - FSM state encoding
//   - small helper functions used by the decoder and error counter
// -----------------------------------------------------------------------------
package mem_bus_mux_pkg;

    // Area / core address prefixes, compared against cpu_addr[31:24]
    localparam logic [7:0] PFX_ROM    = 8'h00;
    localparam logic [7:0] PFX_RAM    = 8'h40;
    localparam logic [7:0] PFX_TRNG   = 8'hc0;
    localparam logic [7:0] PFX_TIMER  = 8'hc1;
    localparam logic [7:0] PFX_UDS    = 8'hc2;
    localparam logic [7:0] PFX_UART   = 8'hc3;
    localparam logic [7:0] PFX_TOUCH  = 8'hc4;
    localparam logic [7:0] PFX_FW_RAM = 8'hd0;
    localparam logic [7:0] PFX_TK1    = 8'hff;

    // Masks: area match uses only the top two address bits, core match all eight
    localparam logic [7:0] MASK_AREA  = 8'hc0;
    localparam logic [7:0] MASK_CORE  = 8'hff;

    localparam logic [31:0] ILLEGAL_INSTRUCTION_DEF = 32'h0000_0000;
    localparam logic [7:0]  ERR_COUNT_MAX           = 8'hff;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_e;

    // Masked prefix compare for one table entry
    function automatic logic prefix_match(input logic [7:0] pfx,
                                          input logic [7:0] base,
                                          input logic [7:0] mask);
        return ((pfx & mask) == (base & mask));
    endfunction

    // Increment that sticks at the maximum value
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == ERR_COUNT_MAX) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_mux_if.sv
// -----------------------------------------------------------------------------
// mem_bus_mux_if
// Bundles the CPU native memory port and the shared downstream core bus.
//   CPU side   : cpu_valid/addr/wdata/wstrb, force_trap -> mem_ready/mem_rdata
//   Core side  : slv_cs (one-hot), slv_we/wstrb/addr/wdata (shared),
//                slv_rdata (flattened, 32 bits per core), slv_ready (per core)
// Modports:
//   slave  - the multiplexer (serves the CPU, drives the cores)
//   master - the environment (CPU and cores)
// -----------------------------------------------------------------------------
interface mem_bus_mux_if #(
    parameter int unsigned NUM_SLAVES = 8
);
    logic                       cpu_valid;
    logic [31:0]                cpu_addr;
    logic [31:0]                cpu_wdata;
    logic [3:0]                 cpu_wstrb;
    logic                       force_trap;
    logic                       mem_ready;
    logic [31:0]                mem_rdata;
    logic [NUM_SLAVES-1:0]      slv_cs;
    logic                       slv_we;
    logic [3:0]                 slv_wstrb;
    logic [31:0]                slv_addr;
    logic [31:0]                slv_wdata;
    logic [32*NUM_SLAVES-1:0]   slv_rdata;
    logic [NUM_SLAVES-1:0]      slv_ready;

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, force_trap,
        input  slv_rdata, slv_ready,
        output mem_ready, mem_rdata,
        output slv_cs, slv_we, slv_wstrb, slv_addr, slv_wdata
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, force_trap,
        output slv_rdata, slv_ready,
        input  mem_ready, mem_rdata,
        input  slv_cs, slv_we, slv_wstrb, slv_addr, slv_wdata
    );
endinterface

// File: rtl/mem_bus_mux_timeout.sv
// -----------------------------------------------------------------------------
// bus_timeout
// 8-bit access timeout counter.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : return the count to zero (wins over enable)
//   enable       : count one waited cycle
//   expired      : count has reached TIMEOUT_CYCLES (count then holds)
// -----------------------------------------------------------------------------
module bus_timeout
    import mem_bus_mux_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear, count up to the limit, or hold
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/mem_bus_mux.sv
// -----------------------------------------------------------------------------
// mem_bus_mux
// Table-driven CPU-to-core memory bus multiplexer with access timeout,
// sticky bus-error status and forced-trap injection.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : CPU port + shared core bus (mem_bus_mux_if.slave)
//   err_clear    : one-cycle pulse clearing bus_err
//   bus_err      : sticky error flag (unmapped access or timeout)
//   err_addr     : cpu_addr of the most recent error
//   err_count    : saturating error counter
// -----------------------------------------------------------------------------
module mem_bus_mux
    import mem_bus_mux_pkg::*;
#(
    parameter int unsigned                 NUM_SLAVES          = 8,
    parameter logic [8*NUM_SLAVES-1:0]     SLAVE_BASE          = {NUM_SLAVES{8'h00}},
    parameter logic [8*NUM_SLAVES-1:0]     SLAVE_MASK          = {NUM_SLAVES{8'hff}},
    parameter int unsigned                 TIMEOUT_CYCLES      = 255,
    parameter logic [31:0]                 ILLEGAL_INSTRUCTION = ILLEGAL_INSTRUCTION_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    mem_bus_mux_if.slave bus,
    input  logic        err_clear,
    output logic        bus_err,
    output logic [31:0] err_addr,
    output logic [7:0]  err_count
);
    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    bus_state_e             state_q, state_d;
    logic [IDX_W-1:0]       sel_q, sel_d;
    logic [IDX_W-1:0]       dec_idx_s, cur_idx_s;
    logic                   dec_hit_s;
    logic                   cur_ready_s;
    logic [31:0]            cur_rdata_s;
    logic [NUM_SLAVES-1:0]  cs_s;
    logic                   expired_s, to_clear_s, to_enable_s;
    logic                   rsp_load_s, err_now_s;
    logic [31:0]            rsp_data_s;

    logic                   mem_ready_q;
    logic [31:0]            mem_rdata_q;
    logic                   bus_err_q;
    logic [31:0]            err_addr_q;
    logic [7:0]             err_count_q;

    // Address decode: scan downwards so the lowest matching index is kept
    always_comb begin
        dec_hit_s = 1'b0;
        dec_idx_s = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (prefix_match(bus.cpu_addr[31:24], SLAVE_BASE[8*i +: 8], SLAVE_MASK[8*i +: 8])) begin
                dec_hit_s = 1'b1;
                dec_idx_s = IDX_W'(i);
            end else begin
                dec_idx_s = dec_idx_s;
            end
        end
    end

    // In ACCESS the latched index is used so later address changes are ignored
    assign cur_idx_s   = (state_q == ST_ACCESS) ? sel_q : dec_idx_s;
    assign cur_ready_s = bus.slv_ready[cur_idx_s];
    assign cur_rdata_s = bus.slv_rdata[32*int'(cur_idx_s) +: 32];

    // State register and latched slave index
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.cpu_valid) begin
                    state_d = ST_IDLE;
                end else if (bus.force_trap || !dec_hit_s || cur_ready_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_ACCESS;
                    sel_d   = dec_idx_s;
                end
            end
            ST_ACCESS: begin
                if (expired_s || cur_ready_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Chip select: independent of slave ready so ready may depend on cs
    always_comb begin
        cs_s = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_valid && !bus.force_trap && dec_hit_s) begin
                    cs_s[dec_idx_s] = 1'b1;
                end else begin
                    cs_s = '0;
                end
            end
            ST_ACCESS: begin
                if (!expired_s) begin
                    cs_s[sel_q] = 1'b1;
                end else begin
                    cs_s = '0;
                end
            end
            default: begin
                cs_s = '0;
            end
        endcase
    end

    // Response and error events for the edge that enters RESP
    always_comb begin
        rsp_load_s = 1'b0;
        rsp_data_s = 32'h0000_0000;
        err_now_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.cpu_valid) begin
                    rsp_load_s = 1'b0;
                end else if (bus.force_trap) begin
                    rsp_load_s = 1'b1;
                    rsp_data_s = ILLEGAL_INSTRUCTION;
                end else if (!dec_hit_s) begin
                    rsp_load_s = 1'b1;
                    err_now_s  = 1'b1;
                end else if (cur_ready_s) begin
                    rsp_load_s = 1'b1;
                    rsp_data_s = cur_rdata_s;
                end else begin
                    rsp_load_s = 1'b0;
                end
            end
            ST_ACCESS: begin
                // A timed-out slave no longer sees cs, so expiry wins over ready
                if (expired_s) begin
                    rsp_load_s = 1'b1;
                    err_now_s  = 1'b1;
                end else if (cur_ready_s) begin
                    rsp_load_s = 1'b1;
                    rsp_data_s = cur_rdata_s;
                end else begin
                    rsp_load_s = 1'b0;
                end
            end
            default: begin
                rsp_load_s = 1'b0;
            end
        endcase
    end

    // Count only cycles where a slave is selected and not yet ready
    assign to_enable_s = (|cs_s) && !cur_ready_s;
    assign to_clear_s  = (state_d != ST_ACCESS);

    bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (to_clear_s),
        .enable  (to_enable_s),
        .expired (expired_s)
    );

    // Registered CPU response and error status
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'h0000_0000;
            bus_err_q   <= 1'b0;
            err_addr_q  <= 32'h0000_0000;
            err_count_q <= 8'd0;
        end else begin
            mem_ready_q <= rsp_load_s;
            if (rsp_load_s) begin
                mem_rdata_q <= rsp_data_s;
            end
            // A new error takes precedence over a simultaneous clear
            if (err_now_s) begin
                bus_err_q   <= 1'b1;
                err_addr_q  <= bus.cpu_addr;
                err_count_q <= sat_inc8(err_count_q);
            end else if (err_clear) begin
                bus_err_q   <= 1'b0;
            end
        end
    end

    // cs is forced low while reset is held, whatever the state register says
    assign bus.slv_cs    = cs_s & {NUM_SLAVES{reset_n}};
    assign bus.slv_we    = |bus.cpu_wstrb;
    assign bus.slv_wstrb = bus.cpu_wstrb;
    assign bus.slv_addr  = bus.cpu_addr;
    assign bus.slv_wdata = bus.cpu_wdata;
    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus_err       = bus_err_q;
    assign err_addr      = err_addr_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_mem_bus_mux.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_mux
// Self-checking bench for mem_bus_mux: directed scenarios followed by random
// accesses, each compared against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_bus_mux;

    localparam int NS = 8;
    localparam int TO = 4;
    // Slave 7 duplicates slave 3 to exercise lowest-index priority
    localparam logic [8*NS-1:0] BASE = {8'hc3, 8'hff, 8'hd0, 8'hc1, 8'hc3, 8'hc0, 8'h40, 8'h00};
    localparam logic [8*NS-1:0] MASK = {8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hc0, 8'hc0};
    localparam logic [31:0] ILL = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic        err_clear;
    logic        bus_err;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    mem_bus_mux_if #(.NUM_SLAVES(NS)) bus ();

    mem_bus_mux #(
        .NUM_SLAVES          (NS),
        .SLAVE_BASE          (BASE),
        .SLAVE_MASK          (MASK),
        .TIMEOUT_CYCLES      (TO),
        .ILLEGAL_INSTRUCTION (ILL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .err_clear (err_clear),
        .bus_err   (bus_err),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    int tests = 0;
    int fails = 0;

    // Core models: ready rises lat[i] cycles after cs first goes high
    int          lat    [NS];
    int          cs_cnt [NS];
    logic [31:0] rd     [NS];

    // Reference model error state
    logic        m_bus_err;
    logic [31:0] m_err_addr;
    logic [7:0]  m_err_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            cs_cnt[i] <= bus.slv_cs[i] ? cs_cnt[i] + 1 : 0;
        end
    end

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            bus.slv_ready[i] = bus.slv_cs[i] && (cs_cnt[i] >= lat[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            bus.slv_rdata[32*i +: 32] = rd[i];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One CPU access; clr_at is the cycle (0 = first valid cycle) where err_clear pulses, -1 = none
    task automatic do_access(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                             input logic ft, input int clr_at, input string tag);
        int          idx;
        int          exp_lat;
        int          exp_cs;
        logic [31:0] exp_data;
        logic        exp_err;
        int          got_lat;
        int          cs_cycles;
        int          cs_bad;

        // Reference: lowest matching table entry wins
        idx = -1;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((addr[31:24] & MASK[8*i +: 8]) == (BASE[8*i +: 8] & MASK[8*i +: 8])) idx = i;
        end
        if (ft) begin
            exp_lat = 1; exp_cs = 0; exp_data = ILL; exp_err = 1'b0;
        end else if (idx < 0) begin
            exp_lat = 1; exp_cs = 0; exp_data = 32'h0; exp_err = 1'b1;
        end else if (lat[idx] < TO) begin
            exp_lat = lat[idx] + 1; exp_cs = lat[idx] + 1; exp_data = rd[idx]; exp_err = 1'b0;
        end else begin
            exp_lat = TO + 1; exp_cs = TO; exp_data = 32'h0; exp_err = 1'b1;
        end

        @(posedge clk); #1;
        bus.cpu_valid  = 1'b1;
        bus.cpu_addr   = addr;
        bus.cpu_wstrb  = wstrb;
        bus.cpu_wdata  = wdata;
        bus.force_trap = ft;
        got_lat = -1; cs_cycles = 0; cs_bad = 0;
        for (int c = 0; c < 40; c++) begin
            err_clear = (c == clr_at);
            @(negedge clk);
            if (c == 0) begin
                chk({tag, ".we"},    {31'h0, bus.slv_we}, {31'h0, |wstrb});
                chk({tag, ".wstrb"}, {28'h0, bus.slv_wstrb}, {28'h0, wstrb});
                chk({tag, ".addr"},  bus.slv_addr, addr);
                chk({tag, ".wdata"}, bus.slv_wdata, wdata);
            end
            if (bus.slv_cs != '0) begin
                cs_cycles++;
                if (idx < 0 || ft || bus.slv_cs != (8'b1 << idx)) cs_bad++;
            end
            if (bus.mem_ready) begin
                got_lat = c;
                break;
            end
            @(posedge clk); #1;
        end

        // Model error state as of the edge that produced mem_ready
        if (exp_err) begin
            m_bus_err   = 1'b1;
            m_err_addr  = addr;
            m_err_count = (m_err_count == 8'hff) ? 8'hff : m_err_count + 8'd1;
        end else if (clr_at >= 0 && clr_at <= exp_lat - 1) begin
            m_bus_err = 1'b0;
        end

        chk({tag, ".latency"},   got_lat, exp_lat);
        chk({tag, ".rdata"},     bus.mem_rdata, exp_data);
        chk({tag, ".cs_cycles"}, cs_cycles, exp_cs);
        chk({tag, ".cs_onehot"}, cs_bad, 0);
        chk({tag, ".bus_err"},   {31'h0, bus_err}, {31'h0, m_bus_err});
        chk({tag, ".err_addr"},  err_addr, m_err_addr);
        chk({tag, ".err_count"}, {24'h0, err_count}, {24'h0, m_err_count});

        // A clear pulse still high during the response cycle lands on the next edge
        if (clr_at == exp_lat) m_bus_err = 1'b0;

        @(posedge clk); #1;
        bus.cpu_valid  = 1'b0;
        bus.force_trap = 1'b0;
        err_clear      = 1'b0;
        @(negedge clk);
        chk({tag, ".one_pulse"}, {31'h0, bus.mem_ready}, 32'h0);
        chk({tag, ".cs_after"},  {24'h0, bus.slv_cs}, 32'h0);
        chk({tag, ".bus_err2"},  {31'h0, bus_err}, {31'h0, m_bus_err});
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, ".mem_ready"}, {31'h0, bus.mem_ready}, 32'h0);
        chk({tag, ".mem_rdata"}, bus.mem_rdata, 32'h0);
        chk({tag, ".bus_err"},   {31'h0, bus_err}, 32'h0);
        chk({tag, ".err_addr"},  err_addr, 32'h0);
        chk({tag, ".err_count"}, {24'h0, err_count}, 32'h0);
    endtask

    initial begin
        logic [7:0]  pfx;
        logic [31:0] a;

        for (int i = 0; i < NS; i++) begin
            lat[i] = 0; cs_cnt[i] = 0; rd[i] = 32'h1000_0000 * i;
        end
        m_bus_err = 1'b0; m_err_addr = 32'h0; m_err_count = 8'h0;
        err_clear      = 1'b0;
        bus.cpu_valid  = 1'b1;
        bus.cpu_addr   = 32'hc300_0004;
        bus.cpu_wdata  = 32'h0;
        bus.cpu_wstrb  = 4'h0;
        bus.force_trap = 1'b0;

        // Reset with a request pending: no cs, all status cleared
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.cs", {24'h0, bus.slv_cs}, 32'h0);
        check_cleared("reset");
        bus.cpu_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);

        // Slave 3, one wait cycle
        lat[3] = 1; rd[3] = 32'hdead_beef;
        do_access(32'hc300_0004, 4'h0, 32'h0, 1'b0, -1, "uart_read");

        // Zero-wait RAM write
        lat[1] = 0;
        do_access(32'h4000_0010, 4'b0011, 32'h1234_5678, 1'b0, -1, "ram_write");

        // Unmapped access
        do_access(32'h8000_0000, 4'h0, 32'h0, 1'b0, -1, "unmapped");

        // Timeout with err_clear on the expiry cycle: error wins
        lat[2] = 1000;
        do_access(32'hc000_0000, 4'h0, 32'h0, 1'b0, TO, "timeout");

        // Stand-alone clear touches only bus_err
        @(posedge clk); #1; err_clear = 1'b1;
        @(posedge clk); #1; err_clear = 1'b0;
        m_bus_err = 1'b0;
        @(negedge clk);
        chk("clear.bus_err",   {31'h0, bus_err}, 32'h0);
        chk("clear.err_addr",  err_addr, m_err_addr);
        chk("clear.err_count", {24'h0, err_count}, {24'h0, m_err_count});

        // Forced trap on a mapped address
        lat[3] = 0;
        do_access(32'hc300_0000, 4'h0, 32'h0, 1'b1, -1, "force_trap");

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 11))
                0:       pfx = 8'(  $urandom_range(0, 63));
                1:       pfx = 8'(64 + $urandom_range(0, 63));
                2:       pfx = 8'hc0;
                3:       pfx = 8'hc1;
                4:       pfx = 8'hc3;
                5:       pfx = 8'hd0;
                6:       pfx = 8'hff;
                7:       pfx = 8'hc4;
                8:       pfx = 8'h80 + 8'($urandom_range(0, 63));
                default: pfx = 8'hc2;
            endcase
            for (int i = 0; i < NS; i++) begin
                lat[i] = $urandom_range(0, 5);
                rd[i]  = $urandom;
            end
            a = {pfx, 24'($urandom)};
            do_access(a, 4'($urandom), $urandom, ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 1)) : -1, "random");
        end

        // Reset in the middle of a stalled access
        lat[2] = 1000;
        @(posedge clk); #1;
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 32'hc000_0008;
        bus.cpu_wstrb = 4'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_access.cs", {24'h0, bus.slv_cs}, 32'h0);
        @(posedge clk); #1;
        bus.cpu_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_bus_err = 1'b0; m_err_addr = 32'h0; m_err_count = 8'h0;
        @(negedge clk);
        check_cleared("rst_access");
        lat[4] = 1; rd[4] = 32'hcafe_f00d;
        do_access(32'hc100_0020, 4'h0, 32'h0, 1'b0, -1, "after_reset");

        // Error counter saturation
        for (int n = 0; n < 256; n++) begin
            do_access({8'h80 + 8'(n % 64), 24'(n)}, 4'h0, 32'h0, 1'b0, -1, "saturate");
        end
        chk("saturate.final", {24'h0, err_count}, 32'h0000_00ff);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
